// File: rtl/iterative_multiplier_if.sv
// Request/response bundle for the iterative multiplier.
// master drives operands and control; slave returns status and product.
interface iterative_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             accumulate;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc_in;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;

    modport master (
        output start, accumulate, op_a, op_b, acc_in, flush,
        input  busy, done, result, flag_n, flag_z
    );

    modport slave (
        input  start, accumulate, op_a, op_b, acc_in, flush,
        output busy, done, result, flag_n, flag_z
    );
endinterface

// File: rtl/iterative_multiplier.sv
// Radix-2 shift-add MUL/MLA unit: one multiplier bit per RUN cycle, low WIDTH bits kept.
// Optional MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module iterative_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iterative_multiplier_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_n;
    logic             r_flag_z;

    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_mplier_next;
    logic             w_last;
    logic             w_accept;

    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_next = r_mplier >> 1;

`ifdef MUL_EARLY_TERM_EN
    assign w_last = (r_count == CNT_W'(WIDTH - 1)) || (w_mplier_next == '0);
`else
    assign w_last = (r_count == CNT_W'(WIDTH - 1));
`endif

    // flush suppresses a new accept in the same cycle; start is ignored while running
    assign w_accept = bus.start && !bus.flush && (r_state != S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_mcand  <= bus.op_a;
                        r_mplier <= bus.op_b;
                        r_acc    <= bus.accumulate ? bus.acc_in : '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= w_mplier_next;
                        r_count  <= r_count + CNT_W'(1);
                        // product and flags are captured on the edge that leaves RUN
                        if (w_last) begin
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_acc_next;
                            r_flag_n <= w_acc_next[WIDTH-1];
                            r_flag_z <= (w_acc_next == '0);
                            r_state  <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.flag_n = r_flag_n;
    assign bus.flag_z = r_flag_z;
endmodule
